// File: rtl/ex_muldiv_if.sv
// ex_muldiv_if: EX-side issue/result bundle for the HI/LO multiply/divide unit.
interface ex_muldiv_if #(parameter int WIDTH = 32);
  logic             start;
  logic [2:0]       op;
  logic [WIDTH-1:0] a_i;
  logic [WIDTH-1:0] b_i;
  logic [WIDTH-1:0] hi_i;
  logic [WIDTH-1:0] lo_i;
  logic             flush;
  logic             busy;
  logic             done;
  logic             whilo_o;
  logic [WIDTH-1:0] hi_o;
  logic [WIDTH-1:0] lo_o;
  modport master (output start, op, a_i, b_i, hi_i, lo_i, flush,
                  input busy, done, whilo_o, hi_o, lo_o);
  modport slave  (input start, op, a_i, b_i, hi_i, lo_i, flush,
                  output busy, done, whilo_o, hi_o, lo_o);
endinterface

// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle HI/LO unit, fixed-latency multiply/accumulate and restoring radix-2 divide.
module ex_muldiv #(
  parameter int WIDTH      = 32,
  parameter int MUL_CYCLES = 3
) (
  input  logic        clk,
  input  logic        rst,
  ex_muldiv_if.slave  bus
);
  localparam int CW = $clog2(WIDTH + MUL_CYCLES) + 1;
  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} state_t;
  state_t           state_q, state_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [2:0]       op_q, op_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d, ahi_q, ahi_d, alo_q, alo_d;
  logic [WIDTH-1:0] rem_q, rem_d, quo_q, quo_d, dvs_q, dvs_d;
  logic [WIDTH-1:0] hi_q, hi_d, lo_q, lo_d;
  logic [WIDTH:0]   trial, diff;
  logic [2*WIDTH-1:0] mul_res, mul_res_i;
  logic             accept, ge, sgn_q;
  function automatic logic [2*WIDTH-1:0] mul_fn(input logic [2:0] op, input logic [WIDTH-1:0] a, b, hi, lo);
    logic [2*WIDTH-1:0] ea, eb, p, acc;
    ea  = op[0] ? {{WIDTH{1'b0}}, a} : {{WIDTH{a[WIDTH-1]}}, a};
    eb  = op[0] ? {{WIDTH{1'b0}}, b} : {{WIDTH{b[WIDTH-1]}}, b};
    p   = ea * eb;
    acc = {hi, lo};
    return op[2:1] == 2'b01 ? acc + p : op[2:1] == 2'b10 ? acc - p : p;
  endfunction
  function automatic logic [WIDTH-1:0] abs_fn(input logic [WIDTH-1:0] x, input logic sgn);
    return (sgn && x[WIDTH-1]) ? -x : x;
  endfunction
  assign bus.busy    = state_q == MUL || state_q == DIV;
  assign bus.done    = state_q == DONE;
  assign bus.whilo_o = state_q == DONE;
  assign bus.hi_o    = hi_q;
  assign bus.lo_o    = lo_q;
  always_comb begin
    accept    = bus.start && !bus.busy && !bus.flush;
    sgn_q     = !op_q[0];
    trial     = {rem_q, quo_q[WIDTH-1]};
    diff      = trial - {1'b0, dvs_q};
    ge        = trial >= {1'b0, dvs_q};
    mul_res   = mul_fn(op_q, a_q, b_q, ahi_q, alo_q);
    mul_res_i = mul_fn(bus.op, bus.a_i, bus.b_i, bus.hi_i, bus.lo_i);
    state_d   = state_q;
    cnt_d     = cnt_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    ahi_d     = ahi_q;
    alo_d     = alo_q;
    rem_d     = rem_q;
    quo_d     = quo_q;
    dvs_d     = dvs_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    case (state_q)
      IDLE, DONE: begin
        state_d = IDLE;
        if (accept) begin
          op_d  = bus.op;
          a_d   = bus.a_i;
          b_d   = bus.b_i;
          ahi_d = bus.hi_i;
          alo_d = bus.lo_i;
          cnt_d = '0;
          if (bus.op[2:1] == 2'b11) begin
            if (bus.b_i == '0) begin
              state_d = DONE;
              hi_d    = bus.a_i;
              lo_d    = '1;
            end else begin
              state_d = DIV;
              rem_d   = '0;
              quo_d   = abs_fn(bus.a_i, !bus.op[0]);
              dvs_d   = abs_fn(bus.b_i, !bus.op[0]);
            end
          end else if (MUL_CYCLES == 1) begin
            state_d      = DONE;
            {hi_d, lo_d} = mul_res_i;
          end else begin
            state_d = MUL;
          end
        end
      end
      MUL: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(MUL_CYCLES > 1 ? MUL_CYCLES - 2 : 0)) begin
          state_d      = DONE;
          {hi_d, lo_d} = mul_res;
        end
      end
      DIV: begin
        cnt_d = cnt_q + 1'b1;
        rem_d = ge ? diff[WIDTH-1:0] : trial[WIDTH-1:0];
        quo_d = {quo_q[WIDTH-2:0], ge};
        // last step: apply sign correction while entering DONE
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = DONE;
          hi_d    = (sgn_q && a_q[WIDTH-1]) ? -rem_d : rem_d;
          lo_d    = (sgn_q && (a_q[WIDTH-1] ^ b_q[WIDTH-1])) ? -quo_d : quo_d;
        end
      end
      default: state_d = IDLE;
    endcase
    if (bus.flush) begin
      state_d = IDLE;
      hi_d    = hi_q;
      lo_d    = lo_q;
    end
  end
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      ahi_q   <= '0;
      alo_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      dvs_q   <= '0;
      hi_q    <= '0;
      lo_q    <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ahi_q   <= ahi_d;
      alo_q   <= alo_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      dvs_q   <= dvs_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end
endmodule
